// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store port to byte-addressed data memory with range/alignment checks, byte-split misaligned accesses and load extension; ports: clk, rst, req_* (MEM-stage request), rsp_* (registered response), misalign_exc/fault_exc/exc_addr (trap pulse), mem_* (data-memory port)
module mem_access_unit #(
  parameter int MEM_BYTES = 100,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign_exc,
  output logic        fault_exc,
  output logic [31:0] exc_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [2:0]  mem_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, SPLIT, RESP, EXC} state_t;
  state_t state, state_nx;
  logic [31:0] base, wd, asm_q, asm_nx;
  logic [2:0] md, sz;
  logic [1:0] k;
  logic we, accept, fault, misal, go, split_go, last, split_act;
  logic [32:0] end_a;
  function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] m);
    return m == 3'd0 ? {{24{d[7]}}, d[7:0]} :
           m == 3'd3 ? {24'd0, d[7:0]} :
           m == 3'd1 ? {{16{d[15]}}, d[15:0]} :
           m == 3'd4 ? {16'd0, d[15:0]} : d;
  endfunction
  always_comb begin
    accept = state == IDLE && req_valid;
    sz = req_mode == 3'd2 ? 3'd4 : (req_mode == 3'd1 || req_mode == 3'd4) ? 3'd2 : 3'd1;
    end_a = {1'b0, req_addr} + {30'd0, sz} - 33'd1;
    fault = req_mode > 3'd4 || end_a >= 33'(MEM_BYTES);
    misal = (sz == 3'd2 && req_addr[0]) || (sz == 3'd4 && req_addr[1:0] != 2'd0);
    go = accept && !fault && !misal;
    split_go = accept && !fault && misal && SPLIT_MISALIGNED;
    split_act = state == SPLIT;
    last = k == (md == 3'd2 ? 2'd3 : (md == 3'd1 || md == 3'd4) ? 2'd1 : 2'd0);
    asm_nx = asm_q | ({24'd0, mem_rdata[7:0]} << {k, 3'b0});
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (go ? RESP : split_go ? SPLIT : accept ? EXC : IDLE) :
               state == SPLIT ? (last ? RESP : SPLIT) : IDLE;
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    mem_rd_en = (go && !req_we) || (split_act && !we);
    mem_wr_en = (go && req_we) || (split_act && we);
    mem_mode = split_act ? 3'd0 : sz == 3'd4 ? 3'd2 : sz == 3'd2 ? 3'd1 : 3'd0;
    mem_addr = split_act ? base + {30'd0, k} : req_addr;
    mem_wdata = split_act ? (wd >> {k, 3'b0}) & 32'hff : req_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      exc_addr <= '0;
      fault_exc <= 1'b0;
      misalign_exc <= 1'b0;
      base <= '0;
      wd <= '0;
      md <= '0;
      we <= 1'b0;
      k <= '0;
      asm_q <= '0;
    end else begin
      fault_exc <= accept && fault;
      misalign_exc <= accept && !fault && misal && !SPLIT_MISALIGNED;
      if (accept && !go && !split_go) exc_addr <= req_addr;
      if (go) rsp_rdata <= req_we ? 32'd0 : ext(mem_rdata, req_mode);
      if (split_go) begin
        base <= req_addr;
        wd <= req_wdata;
        md <= req_mode;
        we <= req_we;
        k <= '0;
        asm_q <= '0;
      end
      if (split_act) begin
        k <= k + 2'd1;
        asm_q <= asm_nx;
        if (last) rsp_rdata <= we ? 32'd0 : ext(asm_nx, md);
      end
    end
  end
endmodule
